i_compare: RTL and testbench



---
 rtl/i_compare.sv | 43 ++++
 tb/tb_i_compare.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/i_compare.sv
// Integer comparator for the ALU flag path: equality and signed/unsigned less-than,
// available combinationally and as a registered, enable-captured copy.
module i_compare #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             is_unsigned,
   input  logic             en,
   output logic             zero,
   output logic             negitive,
   output logic             zero_q,
   output logic             negitive_q,
   output logic             valid_q
);

   logic [WIDTH:0] diff;
   logic           ovf;

   // One subtractor serves both modes: the extra top bit is the unsigned borrow.
   assign diff = {1'b0, a} - {1'b0, b};

   // Signed overflow only when the operand signs differ and the result sign flips from a.
   assign ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);

   assign zero     = (diff[WIDTH-1:0] == '0);
   assign negitive = is_unsigned ? diff[WIDTH] : (diff[WIDTH-1] ^ ovf);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_q     <= 1'b0;
         negitive_q <= 1'b0;
         valid_q    <= 1'b0;
      end else if (en) begin
         zero_q     <= zero;
         negitive_q <= negitive;
         valid_q    <= 1'b1;
      end
   end

endmodule

// File: tb/tb_i_compare.sv
// Self-checking bench for i_compare: directed boundaries, register capture/hold,
// asynchronous reset, and randomized operands against a $signed/unsigned model.
module tb_i_compare;

   localparam int WIDTH = 64;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             is_unsigned;
   logic             en;
   logic             zero;
   logic             negitive;
   logic             zero_q;
   logic             negitive_q;
   logic             valid_q;

   int checks = 0;
   int errors = 0;

   // Reference register state, advanced only by the bench's own model.
   logic exp_zero_q;
   logic exp_neg_q;
   logic exp_valid_q;

   i_compare #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .a          (a),
      .b          (b),
      .is_unsigned(is_unsigned),
      .en         (en),
      .zero       (zero),
      .negitive   (negitive),
      .zero_q     (zero_q),
      .negitive_q (negitive_q),
      .valid_q    (valid_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic model_zero(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
      return x == y;
   endfunction

   function automatic logic model_neg(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                      input logic uns);
      if (uns) return x < y;
      return $signed(x) < $signed(y);
   endfunction

   function automatic logic [WIDTH-1:0] rand_operand();
      logic [WIDTH-1:0] v;
      v = {$urandom, $urandom};
      case ($urandom_range(0, 9))
         0: v = '0;
         1: v = {1'b1, {(WIDTH-1){1'b0}}};
         2: v = {1'b0, {(WIDTH-1){1'b1}}};
         3: v = '1;
         default: ;
      endcase
      return v;
   endfunction

   task automatic check_comb(input string name);
      logic ez, en_;
      ez  = model_zero(a, b);
      en_ = model_neg(a, b, is_unsigned);
      checks++;
      if (zero !== ez) begin
         errors++;
         $display("FAIL %s zero: a=%h b=%h uns=%0b got=%b exp=%b", name, a, b, is_unsigned, zero, ez);
      end
      checks++;
      if (negitive !== en_) begin
         errors++;
         $display("FAIL %s negitive: a=%h b=%h uns=%0b got=%b exp=%b", name, a, b, is_unsigned, negitive, en_);
      end
   endtask

   task automatic check_regs(input string name);
      checks++;
      if ({zero_q, negitive_q, valid_q} !== {exp_zero_q, exp_neg_q, exp_valid_q}) begin
         errors++;
         $display("FAIL %s regs{zero_q,negitive_q,valid_q}: got=%b%b%b exp=%b%b%b", name,
                  zero_q, negitive_q, valid_q, exp_zero_q, exp_neg_q, exp_valid_q);
      end
   endtask

   task automatic apply(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic uns);
      a = x;
      b = y;
      is_unsigned = uns;
      #1;
   endtask

   // Advance one clock edge; the model captures the inputs present at that edge.
   task automatic clock_edge();
      logic cz, cn, ce;
      @(negedge clk);
      cz = model_zero(a, b);
      cn = model_neg(a, b, is_unsigned);
      ce = en;
      @(posedge clk);
      if (rst_n && ce) begin
         exp_zero_q  = cz;
         exp_neg_q   = cn;
         exp_valid_q = 1'b1;
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en = 1'b1;
      apply('0, '0, 1'b0);
      exp_zero_q = 1'b0; exp_neg_q = 1'b0; exp_valid_q = 1'b0;
      check_regs("reset_initial");
      // Enabled edges during reset must not capture.
      repeat (2) clock_edge();
      exp_zero_q = 1'b0; exp_neg_q = 1'b0; exp_valid_q = 1'b0;
      check_regs("reset_held_with_en");
      check_comb("reset_comb_a_eq_b_zero");
      @(negedge clk);
      en = 1'b0;
      rst_n = 1'b1;
      clock_edge();
      check_regs("reset_release_no_en");
   endtask

   task automatic test_directed();
      apply(64'd3, 64'd1, 1'b0);
      check_comb("signed_3_1");
      apply(64'd2, 64'd2, 1'b0);
      check_comb("signed_2_2");
      apply(64'd4, 64'd5, 1'b0);
      check_comb("signed_4_5");
      checks++;
      if (negitive !== 1'b1 || zero !== 1'b0) begin
         errors++;
         $display("FAIL literal_4_5: got zero=%b neg=%b exp zero=0 neg=1", zero, negitive);
      end
   endtask

   task automatic test_sign_mode();
      apply(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      check_comb("signed_m1_1");
      checks++;
      if (negitive !== 1'b1) begin
         errors++;
         $display("FAIL literal_signed_m1_1: got neg=%b exp=1", negitive);
      end
      apply(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
      check_comb("unsigned_max_1");
      checks++;
      if (negitive !== 1'b0) begin
         errors++;
         $display("FAIL literal_unsigned_max_1: got neg=%b exp=0", negitive);
      end
   endtask

   task automatic test_overflow();
      apply(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
      check_comb("signed_overflow");
      checks++;
      if (negitive !== 1'b1 || zero !== 1'b0) begin
         errors++;
         $display("FAIL literal_overflow: got zero=%b neg=%b exp zero=0 neg=1", zero, negitive);
      end
      apply(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
      check_comb("unsigned_overflow_operands");
      apply(64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0);
      check_comb("signed_overflow_reverse");
      apply('0, '0, 1'b1);
      check_comb("unsigned_zero_zero");
   endtask

   task automatic test_capture();
      @(negedge clk);
      en = 1'b1;
      apply(64'd4, 64'd5, 1'b0);
      clock_edge();
      check_regs("capture_4_5");
      checks++;
      if ({zero_q, negitive_q, valid_q} !== 3'b011) begin
         errors++;
         $display("FAIL literal_capture: got=%b%b%b exp=011", zero_q, negitive_q, valid_q);
      end
      @(negedge clk);
      en = 1'b0;
      apply(64'd2, 64'd2, 1'b0);
      repeat (3) clock_edge();
      check_regs("hold_en0");
      // Mid-cycle input changes with en=1 still wait for the edge.
      en = 1'b1;
      apply(64'd9, 64'd9, 1'b0);
      check_regs("mid_cycle_no_update");
      clock_edge();
      check_regs("capture_eq");
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      en = 1'b1;
      apply(64'd1, 64'd7, 1'b1);
      clock_edge();
      check_regs("pre_reset_capture");
      #3;
      rst_n = 1'b0;
      #1;
      exp_zero_q = 1'b0; exp_neg_q = 1'b0; exp_valid_q = 1'b0;
      check_regs("async_reset_mid_cycle");
      apply(64'd5, 64'd5, 1'b0);
      check_comb("comb_during_reset_eq");
      apply(64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 1'b0);
      check_comb("comb_during_reset_lt");
      clock_edge();
      check_regs("reset_wins_over_en");
      @(negedge clk);
      rst_n = 1'b1;
      clock_edge();
      check_regs("capture_after_release");
   endtask

   task automatic test_random_comb();
      for (int i = 0; i < 10000; i++) begin
         logic [WIDTH-1:0] x, y;
         x = rand_operand();
         y = ($urandom_range(0, 7) == 0) ? x : rand_operand();
         apply(x, y, 1'($urandom_range(0, 1)));
         check_comb("random_comb");
         checks++;
         if (zero && negitive) begin
            errors++;
            $display("FAIL random_exclusive: a=%h b=%h both flags set", a, b);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         en = 1'($urandom_range(0, 3) != 0);
         apply(rand_operand(), ($urandom_range(0, 5) == 0) ? a : rand_operand(),
               1'($urandom_range(0, 1)));
         check_comb("b2b_comb");
         clock_edge();
         check_regs("b2b_regs");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_sign_mode();
      test_overflow();
      test_capture();
      test_async_reset();
      test_random_comb();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("FAIL timeout: got=running exp=finished");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
